display_axil_cfg_arbiter: RTL and testbench

Shares the single AXI4-Lite configuration port of the MIPI DSI TX controller between two requesters: port 0, the panel init sequencer, and port 1, the debug/host register bridge. Each requester issues one single-beat read or write over a hold-until-ack request interface. The block arbitrates round-robin and runs the AXI-Lite write (AW/W/B) or read (AR/R) handshake. It returns read data and a per-port ack/error, and aborts stalled transactions on a programmable timeout.

---
 rtl/display_axil_cfg_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_display_axil_cfg_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_axil_cfg_arbiter.sv
// display_axil_cfg_arbiter
//   Shares the AXI4-Lite configuration port of the DSI TX controller between
//   two single-beat requesters (port 0: panel init sequencer, port 1: debug
//   host bridge). Round-robin arbitration, one transaction at a time, with a
//   programmable watchdog that aborts a stalled transaction.
// Ports:
//   i_axi_clk / i_arst        clock, asynchronous active-high reset
//   i_req/i_we/i_addr/i_wdata per-port hold-until-ack request (packed per port)
//   o_ack/o_err/o_rdata       one-cycle completion pulse, error flag, read data
//   o_grant/o_busy/o_state    current owner and FSM state for debug
//   o_axi_* / i_axi_*         AXI4-Lite manager side (AW/W/B and AR/R)
module display_axil_cfg_arbiter #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic                    i_axi_clk,
  input  logic                    i_arst,
  input  logic [1:0]              i_req,
  input  logic [1:0]              i_we,
  input  logic [2*ADDR_WIDTH-1:0] i_addr,
  input  logic [63:0]             i_wdata,
  output logic [1:0]              o_ack,
  output logic [1:0]              o_err,
  output logic [31:0]             o_rdata,
  output logic [1:0]              o_grant,
  output logic                    o_busy,
  output logic [2:0]              o_state,
  output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic                    o_axi_awvalid,
  input  logic                    i_axi_awready,
  output logic [31:0]             o_axi_wdata,
  output logic                    o_axi_wvalid,
  input  logic                    i_axi_wready,
  input  logic                    i_axi_bvalid,
  input  logic [1:0]              i_axi_bresp,
  output logic                    o_axi_bready,
  output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic                    o_axi_arvalid,
  input  logic                    i_axi_arready,
  input  logic                    i_axi_rvalid,
  input  logic [1:0]              i_axi_rresp,
  input  logic [31:0]             i_axi_rdata,
  output logic                    o_axi_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            state_q,   state_d;
  logic [1:0]            grant_q,   grant_d;
  logic                  r_last_q,  r_last_d;
  logic [15:0]           cnt_q,     cnt_d;
  logic                  err_q,     err_d;
  logic [31:0]           rdata_q,   rdata_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [31:0]           wdata_q,   wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;

  logic sel;
  logic timeout_hit;

  // The watchdog fires on the cycle the incremented count would equal
  // TIMEOUT, so a stalled valid is held for exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 16'd0) && ((cnt_q + 16'd1) == TIMEOUT);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    r_last_d  = r_last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    // On a tie the port not served last wins; a lone request wins outright.
    sel = (i_req == 2'b11) ? ~r_last_q : i_req[1];

    case (state_q)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          grant_d  = sel ? 2'b10 : 2'b01;
          r_last_d = sel;
          cnt_d    = 16'd0;
          err_d    = 1'b0;
          if (i_we[sel]) begin
            awaddr_d  = sel ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
            wdata_d   = sel ? i_wdata[63:32] : i_wdata[31:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = sel ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = awvalid_q & ~i_axi_awready;
        wvalid_d  = wvalid_q & ~i_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (i_axi_bvalid) begin
          bready_d = 1'b0;
          err_d    = (i_axi_bresp != 2'b00);
          state_d  = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (i_axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = i_axi_rdata;
          err_d    = (i_axi_rresp != 2'b00);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Watchdog for every waiting state; an abort overrides any handshake
    // seen in the same cycle.
    if (state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA}) begin
      cnt_d = cnt_q + 16'd1;
      if (timeout_hit) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        err_d     = 1'b1;
        state_d   = S_DONE;
      end
    end
  end

  always_ff @(posedge i_axi_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      r_last_q  <= 1'b1;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      r_last_q  <= r_last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign o_ack         = (state_q == S_DONE) ? grant_q : 2'b00;
  assign o_err         = (state_q == S_DONE && err_q) ? grant_q : 2'b00;
  assign o_rdata       = rdata_q;
  assign o_grant       = grant_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_state       = state_q;
  assign o_axi_awaddr  = awaddr_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_display_axil_cfg_arbiter.sv
// Directed bench for display_axil_cfg_arbiter with a small AXI4-Lite slave
// model whose stalls and responses are set per test.
module tb_display_axil_cfg_arbiter;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    i_req = '0, i_we = '0;
  logic [2*AW-1:0] i_addr = '0;
  logic [63:0]   i_wdata = '0;
  logic [1:0]    o_ack, o_err, o_grant;
  logic [31:0]   o_rdata;
  logic          o_busy;
  logic [2:0]    o_state;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0]   wdata;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0]   rdata_cfg = 32'd0;

  // slave configuration
  int   aw_stall = 0;       // awvalid cycles seen before awready rises
  logic ar_block = 1'b0;    // never accept AR
  logic b_block  = 1'b0;    // withhold the write response
  int   aw_cnt;
  logic aw_seen, w_seen, b_pend, r_pend;

  int checks = 0, errs = 0;
  int cyc, awv_n, wv_n, arv_n;

  always #5 clk = ~clk;

  display_axil_cfg_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(16'd16)) dut (
    .i_axi_clk(clk), .i_arst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_grant(o_grant),
    .o_busy(o_busy), .o_state(o_state),
    .o_axi_awaddr(awaddr), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bvalid(bvalid), .i_axi_bresp(bresp_cfg), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rvalid(rvalid), .i_axi_rresp(rresp_cfg), .i_axi_rdata(rdata_cfg),
    .o_axi_rready(rready)
  );

  // Slave: B is raised the cycle after both AW and W have handshaken,
  // R the cycle after the AR handshake.
  assign awready = (aw_cnt >= aw_stall);
  assign wready  = 1'b1;
  assign arready = !ar_block;
  assign bvalid  = b_pend && !b_block;
  assign rvalid  = r_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (bvalid && bready) b_pend <= 1'b0;
      if (((awvalid && awready) || aw_seen) && ((wvalid && wready) || w_seen)) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        if (awvalid && awready) aw_seen <= 1'b1;
        if (wvalid && wready) w_seen <= 1'b1;
      end
      if (arvalid && arready) r_pend <= 1'b1;
      else if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called at a negedge; returns the number of cycles until o_ack shows.
  task automatic run_until_ack(output int n);
    n = 0; awv_n = 0; wv_n = 0; arv_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (awvalid) awv_n++;
      if (wvalid)  wv_n++;
      if (arvalid) arv_n++;
    end while (o_ack == 2'b00 && n < 100);
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_valid", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check("rst_ack",   32'(o_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- port 0 write, always-ready slave ----
    i_req = 2'b01; i_we = 2'b01; i_addr[AW-1:0] = 7'h24; i_wdata[31:0] = 32'h0000_0C00;
    @(negedge clk);
    check("wr_state1", 32'(o_state), 32'd1);
    check("wr_awv_wv", 32'({awvalid, wvalid}), 32'd3);
    check("wr_grant",  32'(o_grant), 32'd1);
    check("wr_busy",   32'(o_busy), 32'd1);
    check("wr_awaddr", 32'(awaddr), 32'h24);
    check("wr_wdata",  wdata, 32'h0000_0C00);
    run_until_ack(cyc);
    check("wr_latency", 32'(cyc + 1), 32'd3);
    check("wr_ack", 32'(o_ack), 32'd1);
    check("wr_err", 32'(o_err), 32'd0);
    i_req = 2'b00;
    @(negedge clk);
    check("wr_idle",  32'(o_state), 32'd0);
    check("wr_ungrant", 32'(o_grant), 32'd0);
    check("wr_hold_addr", 32'(awaddr), 32'h24);

    // ---- tie right after reset: port 0 first ----
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    rdata_cfg = 32'hDEAD_BEEF;
    i_we = 2'b01; i_addr = {7'h10, 7'h30}; i_wdata = {32'h0, 32'h0000_00A5};
    i_req = 2'b11;
    run_until_ack(cyc);
    check("tie1_latency", 32'(cyc), 32'd3);
    check("tie1_ack", 32'(o_ack), 32'd1);
    check("tie1_awaddr", 32'(awaddr), 32'h30);
    i_req = 2'b10;
    @(negedge clk);
    check("tie1_idle", 32'(o_state), 32'd0);
    i_req = 2'b11;            // port 0 re-requests: second tie, port 1 was not served last
    run_until_ack(cyc);
    check("tie2_latency", 32'(cyc), 32'd3);
    check("tie2_ack", 32'(o_ack), 32'd2);
    check("tie2_rdata", o_rdata, 32'hDEAD_BEEF);
    check("tie2_araddr", 32'(araddr), 32'h10);
    check("tie2_err", 32'(o_err), 32'd0);
    i_req = 2'b01;
    run_until_ack(cyc);
    check("tie3_latency", 32'(cyc), 32'd4);
    check("tie3_ack", 32'(o_ack), 32'd1);
    i_req = 2'b00;
    @(negedge clk);

    // ---- awready stalled, wready immediate ----
    aw_stall = 4;
    i_we = 2'b01; i_addr[AW-1:0] = 7'h08; i_wdata[31:0] = 32'h1111_2222;
    i_req = 2'b01;
    run_until_ack(cyc);
    check("awstall_awv_cycles", 32'(awv_n), 32'd5);
    check("awstall_wv_cycles",  32'(wv_n), 32'd1);
    check("awstall_latency", 32'(cyc), 32'd7);
    check("awstall_ack", 32'(o_ack), 32'd1);
    i_req = 2'b00;
    @(negedge clk);
    check("awstall_single_ack", 32'(o_ack), 32'd0);
    aw_stall = 0;

    // ---- read timeout on port 1 ----
    ar_block = 1'b1;
    i_we = 2'b00; i_addr[2*AW-1:AW] = 7'h44;
    i_req = 2'b10;
    run_until_ack(cyc);
    check("to_arv_cycles", 32'(arv_n), 32'd16);
    check("to_latency", 32'(cyc), 32'd17);
    check("to_ack", 32'(o_ack), 32'd2);
    check("to_err", 32'(o_err), 32'd2);
    check("to_arvalid", 32'(arvalid), 32'd0);
    i_req = 2'b00;
    @(negedge clk);
    check("to_idle", 32'(o_state), 32'd0);
    ar_block = 1'b0;

    // ---- error responses ----
    rresp_cfg = 2'b10; rdata_cfg = 32'h1234_5678;
    i_we = 2'b00; i_addr[AW-1:0] = 7'h0C;
    i_req = 2'b01;
    run_until_ack(cyc);
    check("rresp_ack", 32'(o_ack), 32'd1);
    check("rresp_err", 32'(o_err), 32'd1);
    check("rresp_rdata", o_rdata, 32'h1234_5678);
    i_req = 2'b00;
    @(negedge clk);
    rresp_cfg = 2'b00; bresp_cfg = 2'b11;
    i_we = 2'b10; i_addr[2*AW-1:AW] = 7'h50; i_wdata[63:32] = 32'hCAFE_0001;
    i_req = 2'b10;
    run_until_ack(cyc);
    check("bresp_ack", 32'(o_ack), 32'd2);
    check("bresp_err", 32'(o_err), 32'd2);
    check("bresp_wdata", wdata, 32'hCAFE_0001);
    i_req = 2'b00;
    @(negedge clk);
    bresp_cfg = 2'b00;

    // ---- reset during WR_RESP, then the held request completes ----
    b_block = 1'b1;
    i_we = 2'b01; i_addr[AW-1:0] = 7'h24; i_wdata[31:0] = 32'h0000_0C00;
    i_req = 2'b01;
    repeat (2) @(negedge clk);
    check("mid_state_wr_resp", 32'(o_state), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_bready", 32'(bready), 32'd0);
    check("mid_rst_grant", 32'(o_grant), 32'd0);
    check("mid_rst_awaddr", 32'(awaddr), 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; b_block = 1'b0;
    run_until_ack(cyc);
    check("post_rst_latency", 32'(cyc), 32'd3);
    check("post_rst_ack", 32'(o_ack), 32'd1);
    check("post_rst_err", 32'(o_err), 32'd0);
    i_req = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
